// File: rtl/ecm_pkg.sv
// Shared types and sizing helpers for the ECM result framer.
package ecm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } frame_state_e;

  localparam logic [7:0] SYNC0_DEFAULT = 8'h55;
  localparam logic [7:0] SYNC1_DEFAULT = 8'hAA;

  // Bytes on the wire: two sync, two length, payload, optional checksum.
  function automatic int frame_total(input int num_width, input int num_cnt, input int chk_en);
    return 4 + (num_cnt * num_width) / 8 + chk_en;
  endfunction

  // Width able to hold every value 0..count, so count itself never wraps.
  function automatic int index_width(input int count);
    return (count < 2) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/ecm_result_framer_if.sv
// Bundle between the ECM core / UARTtx and the result framer.
interface ecm_result_framer_if
  import ecm_pkg::*;
#(
  parameter int NUM_WIDTH = 256,
  parameter int NUM_CNT   = 2
) ();

  logic                           capture;
  logic [NUM_CNT*NUM_WIDTH-1:0]   num_in;
  logic                           busy;
  logic [7:0]                     tx_data;
  logic                           tx_send;
  logic                           tx_idle;
  logic                           frame_done;
  logic                           overrun;
  frame_state_e                   state;

  // UART handshake: tx_send is a one-cycle strobe issued only while tx_idle=1;
  // the byte counts as accepted once tx_idle falls and as finished once it rises
  // again. tx_data is held from the strobe until the next strobe.
  modport master (
    input  capture, num_in, tx_idle,
    output busy, tx_data, tx_send, frame_done, overrun, state
  );

  modport slave (
    output capture, num_in, tx_idle,
    input  busy, tx_data, tx_send, frame_done, overrun, state
  );

endinterface

// File: rtl/uart_byte_sender.sv
// Per-byte send/idle handshake with UARTtx, plus frame busy/done flags.
module uart_byte_sender
  import ecm_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         last,
  input  logic [7:0]   byte_in,
  input  logic         tx_idle,
  output logic [7:0]   tx_data,
  output logic         tx_send,
  output logic         busy,
  output logic         done,
  output logic         advance,
  output frame_state_e state
);

  // Current byte finished and another follows; the framer bumps its index here.
  assign advance = (state == ST_WAIT_DONE) && tx_idle && !done && !last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tx_data <= 8'h00;
      tx_send <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      tx_send <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_idle) begin
            tx_data <= byte_in;
            tx_send <= 1'b1;
            state   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (!tx_idle) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // The done pulse cycle is still spent here so a capture in it is refused.
          if (done) begin
            state <= ST_IDLE;
          end else if (tx_idle) begin
            if (last) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              state <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ecm_result_framer.sv
// Snapshots NUM_CNT result words and streams them as one framed byte sequence.
module ecm_result_framer
  import ecm_pkg::*;
#(
  parameter int         NUM_WIDTH   = 256,
  parameter int         NUM_CNT     = 2,
  parameter logic [7:0] SYNC0       = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1       = SYNC1_DEFAULT,
  parameter int         CHECKSUM_EN = 1
) (
  input  logic                clock,
  input  logic                reset,
  ecm_result_framer_if.master bus
);

  localparam int TOTW  = NUM_CNT * NUM_WIDTH;
  localparam int PAY   = TOTW / 8;
  localparam int TOTAL = frame_total(NUM_WIDTH, NUM_CNT, CHECKSUM_EN);
  localparam int IDXW  = index_width(TOTAL);
  localparam int PIW   = (PAY < 2) ? 1 : $clog2(PAY);

  localparam logic [15:0]     LEN_BITS = 16'(TOTW);
  localparam logic [IDXW-1:0] IDX_PAY0 = IDXW'(4);
  localparam logic [IDXW-1:0] IDX_CHK  = IDXW'(4 + PAY);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(TOTAL - 1);

  logic [TOTW-1:0] snapshot;
  logic [IDXW-1:0] idx;
  logic [7:0]      chk;
  logic            overrun_q;
  logic [7:0]      pay_bytes [PAY];
  logic [PIW-1:0]  pay_sel;
  logic [7:0]      cur_byte;
  logic            start;
  logic            last;
  logic            advance;
  frame_state_e    state;

  // Payload byte 0 is the most significant byte of word 0.
  for (genvar g = 0; g < PAY; g++) begin : g_pay
    assign pay_bytes[g] = snapshot[TOTW-1-8*g -: 8];
  end

  assign start = bus.capture && (state == ST_IDLE);
  assign last  = (idx == IDX_LAST);

  always_comb begin
    pay_sel = PIW'(idx - IDX_PAY0);
    if (idx == IDXW'(0))      cur_byte = SYNC0;
    else if (idx == IDXW'(1)) cur_byte = SYNC1;
    else if (idx == IDXW'(2)) cur_byte = LEN_BITS[15:8];
    else if (idx == IDXW'(3)) cur_byte = LEN_BITS[7:0];
    else if (idx < IDX_CHK)   cur_byte = pay_bytes[pay_sel];
    else                      cur_byte = chk;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snapshot  <= '0;
      idx       <= '0;
      chk       <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      if (start) begin
        snapshot  <= bus.num_in;
        idx       <= '0;
        chk       <= 8'h00;
        overrun_q <= 1'b0;
      end else if (bus.capture) begin
        overrun_q <= 1'b1;
      end
      // Sync bytes stay out of the checksum; the checksum byte is always last.
      if (advance) begin
        idx <= idx + IDXW'(1);
        if (idx >= IDXW'(2)) chk <= chk ^ cur_byte;
      end
    end
  end

  assign bus.overrun = overrun_q;
  assign bus.state   = state;

  uart_byte_sender u_sender (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .last    (last),
    .byte_in (cur_byte),
    .tx_idle (bus.tx_idle),
    .tx_data (bus.tx_data),
    .tx_send (bus.tx_send),
    .busy    (bus.busy),
    .done    (bus.frame_done),
    .advance (advance),
    .state   (state)
  );

endmodule

// File: tb/tb_ecm_result_framer.sv
// Bench for ecm_result_framer: default 2x256 framer and a 1x16 no-checksum framer.
module tb_ecm_result_framer;
  import ecm_pkg::*;

  localparam int UART_BUSY_A = 10;
  localparam int WAIT_LIMIT  = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ecm_result_framer_if #(.NUM_WIDTH(256), .NUM_CNT(2)) bus_a ();
  ecm_result_framer_if #(.NUM_WIDTH(16),  .NUM_CNT(1)) bus_b ();

  ecm_result_framer dut_a (.clock(clk), .reset(rst_n), .bus(bus_a));
  ecm_result_framer #(.NUM_WIDTH(16), .NUM_CNT(1), .CHECKSUM_EN(0))
    dut_b (.clock(clk), .reset(rst_n), .bus(bus_b));

  // ---------------- UART models ----------------
  int         cnt_a = 0;
  int         cnt_b = 0;
  logic       hold_a = 1'b0;
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];

  assign bus_a.tx_idle = (cnt_a == 0) && !hold_a;
  assign bus_b.tx_idle = (cnt_b == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_a <= 0;
    else if (bus_a.tx_send) begin
      cnt_a <= UART_BUSY_A;
      got_a.push_back(bus_a.tx_data);
    end else if (cnt_a > 0) cnt_a <= cnt_a - 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_b <= 0;
    else if (bus_b.tx_send) begin
      cnt_b <= int'($urandom_range(2, 12));
      got_b.push_back(bus_b.tx_data);
    end else if (cnt_b > 0) cnt_b <= cnt_b - 1;
  end

  // ---------------- protocol monitors ----------------
  int dbl_a = 0, stab_a = 0, nobusy_a = 0, fd_a = 0;
  int dbl_b = 0, stab_b = 0, nobusy_b = 0, fd_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_a <= 1'b0;
      last_a <= 8'h00;
    end else begin
      if (bus_a.tx_send && prev_a) dbl_a <= dbl_a + 1;
      if (bus_a.tx_send && !bus_a.busy) nobusy_a <= nobusy_a + 1;
      if (!bus_a.tx_send && bus_a.tx_data !== last_a) stab_a <= stab_a + 1;
      if (bus_a.tx_send) last_a <= bus_a.tx_data;
      if (bus_a.frame_done) fd_a <= fd_a + 1;
      prev_a <= bus_a.tx_send;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_b <= 1'b0;
      last_b <= 8'h00;
    end else begin
      if (bus_b.tx_send && prev_b) dbl_b <= dbl_b + 1;
      if (bus_b.tx_send && !bus_b.busy) nobusy_b <= nobusy_b + 1;
      if (!bus_b.tx_send && bus_b.tx_data !== last_b) stab_b <= stab_b + 1;
      if (bus_b.tx_send) last_b <= bus_b.tx_data;
      if (bus_b.frame_done) fd_b <= fd_b + 1;
      prev_b <= bus_b.tx_send;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic build_frame(input logic [511:0] snap, input int width, input int cnt,
                             input int chk_en);
    int total_bits;
    logic [7:0] x;
    total_bits = width * cnt;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'(total_bits >> 8));
    exp_q.push_back(8'(total_bits));
    for (int i = 0; i < total_bits / 8; i++)
      exp_q.push_back(8'(snap >> (total_bits - 8 * (i + 1))));
    if (chk_en != 0) begin
      x = 8'h00;
      for (int i = 2; i < exp_q.size(); i++) x = x ^ exp_q[i];
      exp_q.push_back(x);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input bit sel, input string tag);
    int n;
    n = sel ? got_b.size() : got_a.size();
    check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), sel ? 32'(got_b[i]) : 32'(got_a[i]), 32'(exp_q[i]));
    if (sel) got_b.delete(); else got_a.delete();
  endtask

  task automatic wait_done(input bit sel, input string tag, output int busy_gaps);
    int k;
    busy_gaps = 0;
    for (k = 0; k < WAIT_LIMIT; k++) begin
      if (sel ? bus_b.frame_done : bus_a.frame_done) break;
      if (!(sel ? bus_b.busy : bus_a.busy)) busy_gaps++;
      tick();
    end
    check({tag, "_frame_done_seen"}, 32'(k < WAIT_LIMIT), 32'd1);
  endtask

  task automatic cap_a(input logic [511:0] v);
    bus_a.num_in  = v;
    bus_a.capture = 1'b1;
    tick();
    bus_a.capture = 1'b0;
  endtask

  task automatic cap_b(input logic [15:0] v);
    bus_b.num_in  = v;
    bus_b.capture = 1'b1;
    tick();
    bus_b.capture = 1'b0;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [511:0] v;
    logic [15:0]  vb;
    int gaps, fd0, k;
    logic quiet;

    bus_a.capture = 1'b0;
    bus_a.num_in  = '0;
    bus_b.capture = 1'b0;
    bus_b.num_in  = '0;
    repeat (3) tick();

    // Reset values, still in reset and right after release.
    check("rst_busy_a", 32'(bus_a.busy), 32'd0);
    check("rst_send_a", 32'(bus_a.tx_send), 32'd0);
    check("rst_data_a", 32'(bus_a.tx_data), 32'h00);
    check("rst_done_a", 32'(bus_a.frame_done), 32'd0);
    check("rst_ovr_a", 32'(bus_a.overrun), 32'd0);
    check("rst_state_a", 32'(bus_a.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    check("rel_busy_b", 32'(bus_b.busy), 32'd0);
    check("rel_send_b", 32'(bus_b.tx_send), 32'd0);
    check("rel_ovr_b", 32'(bus_b.overrun), 32'd0);

    // Default frame, latency, busy span and single frame_done; num_in changes after capture.
    v = {256'h0A, 256'h11};
    build_frame(v, 256, 2, 1);
    fd0 = fd_a;
    cap_a(v);
    bus_a.num_in = rand512();
    check("t1_busy_next_cycle", 32'(bus_a.busy), 32'd1);
    check("t1_no_send_yet", 32'(bus_a.tx_send), 32'd0);
    tick();
    check("t1_send_latency", 32'(bus_a.tx_send), 32'd1);
    check("t1_first_byte", 32'(bus_a.tx_data), 32'h55);
    wait_done(1'b0, "t1", gaps);
    check("t1_busy_gaps", 32'(gaps), 32'd0);
    check("t1_busy_low_at_done", 32'(bus_a.busy), 32'd0);
    repeat (3) tick();
    check("t1_done_pulses", 32'(fd_a - fd0), 32'd1);
    compare_frame(1'b0, "t1");

    // Narrow framer without checksum.
    build_frame(512'hBEEF, 16, 1, 0);
    cap_b(16'hBEEF);
    wait_done(1'b1, "t2", gaps);
    tick();
    compare_frame(1'b1, "t2");

    // Random words on both framers.
    for (int r = 0; r < 3; r++) begin
      vb = 16'($urandom);
      build_frame({496'b0, vb}, 16, 1, 0);
      cap_b(vb);
      wait_done(1'b1, "rnd_b", gaps);
      tick();
      compare_frame(1'b1, $sformatf("rnd_b%0d", r));
    end
    for (int r = 0; r < 2; r++) begin
      v = rand512();
      build_frame(v, 256, 2, 1);
      cap_a(v);
      wait_done(1'b0, "rnd_a", gaps);
      tick();
      compare_frame(1'b0, $sformatf("rnd_a%0d", r));
    end

    // Capture during a frame: ignored, sticky overrun, cleared by next accepted capture.
    v = rand512();
    build_frame(v, 256, 2, 1);
    cap_a(v);
    for (k = 0; k < WAIT_LIMIT && got_a.size() < 5; k++) tick();
    check("t3_reached_byte5", 32'(k < WAIT_LIMIT), 32'd1);
    cap_a(rand512());
    check("t3_overrun_set", 32'(bus_a.overrun), 32'd1);
    check("t3_still_busy", 32'(bus_a.busy), 32'd1);
    wait_done(1'b0, "t3", gaps);
    tick();
    compare_frame(1'b0, "t3");
    check("t3_overrun_sticky", 32'(bus_a.overrun), 32'd1);
    v = rand512();
    build_frame(v, 256, 2, 1);
    cap_a(v);
    check("t3_overrun_cleared", 32'(bus_a.overrun), 32'd0);
    wait_done(1'b0, "t3b", gaps);
    tick();
    compare_frame(1'b0, "t3b");

    // UART not idle for 50 cycles before the first byte.
    hold_a = 1'b1;
    v = rand512();
    build_frame(v, 256, 2, 1);
    cap_a(v);
    quiet = 1'b1;
    repeat (50) begin
      if (bus_a.tx_send) quiet = 1'b0;
      tick();
    end
    check("t4_no_send_while_held", 32'(quiet), 32'd1);
    hold_a = 1'b0;
    tick();
    check("t4_send_after_idle", 32'(bus_a.tx_send), 32'd1);
    check("t4_sync0", 32'(bus_a.tx_data), 32'h55);
    tick();
    check("t4_send_single", 32'(bus_a.tx_send), 32'd0);
    wait_done(1'b0, "t4", gaps);
    tick();
    compare_frame(1'b0, "t4");

    // Reset while payload byte 20 is being strobed.
    v = rand512();
    build_frame(v, 256, 2, 1);
    cap_a(v);
    for (k = 0; k < WAIT_LIMIT && !(bus_a.tx_send && got_a.size() == 24); k++) tick();
    check("t5_reached_byte20", 32'(k < WAIT_LIMIT), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_send_drops", 32'(bus_a.tx_send), 32'd0);
    check("t5_busy_drops", 32'(bus_a.busy), 32'd0);
    check("t5_data_cleared", 32'(bus_a.tx_data), 32'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    got_a.delete();
    check("t5_idle_after_reset", 32'(bus_a.state), 32'(ST_IDLE));
    v = rand512();
    build_frame(v, 256, 2, 1);
    cap_a(v);
    wait_done(1'b0, "t5", gaps);
    tick();
    compare_frame(1'b0, "t5");

    // Capture in the frame_done cycle is refused.
    vb = 16'($urandom);
    build_frame({496'b0, vb}, 16, 1, 0);
    fd0 = fd_b;
    cap_b(vb);
    wait_done(1'b1, "t6", gaps);
    cap_b(16'($urandom));
    check("t6_overrun_set", 32'(bus_b.overrun), 32'd1);
    check("t6_not_busy", 32'(bus_b.busy), 32'd0);
    quiet = 1'b1;
    repeat (30) begin
      if (bus_b.tx_send || bus_b.busy) quiet = 1'b0;
      tick();
    end
    check("t6_no_second_frame", 32'(quiet), 32'd1);
    check("t6_done_pulses", 32'(fd_b - fd0), 32'd1);
    compare_frame(1'b1, "t6");

    // Handshake rules over the whole run.
    check("mon_double_send_a", 32'(dbl_a), 32'd0);
    check("mon_data_stable_a", 32'(stab_a), 32'd0);
    check("mon_send_busy_a", 32'(nobusy_a), 32'd0);
    check("mon_double_send_b", 32'(dbl_b), 32'd0);
    check("mon_data_stable_b", 32'(stab_b), 32'd0);
    check("mon_send_busy_b", 32'(nobusy_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecm_result_framer.md
Name: ecm_result_framer

Overview:
- Parametrised successor to the ad-hoc ECM result-to-UART serializer in the ECM top level.
- Snapshots NUM_CNT results of NUM_WIDTH bits each (e.g. ladder X_out/Z_out) on a capture pulse, then emits one framed byte stream through the existing UARTtx send/idle handshake.
- Frame layout: sync, length, MSB-first payload, optional XOR checksum.
- Sits between the ECM compute core (mont_ladder / ECM controller) and UARTtx.

Parameters:
- NUM_WIDTH, 256, bits per result word; must be a multiple of 8 and 8..2048.
- NUM_CNT, 2, number of result words per frame; 1..8.
- SYNC0, 8'h55, first sync byte.
- SYNC1, 8'hAA, second sync byte.
- CHECKSUM_EN, 1, 1 appends an XOR checksum byte; 0 omits it.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- capture  in  1  single-cycle pulse; latch num_in and start a frame.
- num_in  in  NUM_CNT*NUM_WIDTH  results; word 0 occupies the top NUM_WIDTH bits.
- busy  out  1  high from the cycle after an accepted capture until frame_done.
- tx_data  out  8  byte to UARTtx.data.
- tx_send  out  1  one-cycle send strobe to UARTtx.send.
- tx_idle  in  1  UARTtx.idle.
- frame_done  out  1  one-cycle pulse after the last byte's tx_idle returns high.
- overrun  out  1  sticky; a capture arrived while busy.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, tx_data=8'h00, tx_send=0, frame_done=0, overrun=0, byte index=0, snapshot register=0.
- Frame length: PAY = NUM_CNT*NUM_WIDTH/8. TOTAL = 4 + PAY + CHECKSUM_EN. Defaults give 69 bytes.
- Byte order:
  - SYNC0, SYNC1.
  - LEN_HI, LEN_LO = 16-bit payload bit count NUM_CNT*NUM_WIDTH. The default is 0x0200.
  - Payload bytes from snapshot bit [top:top-7] downward.
  - CHK = XOR of LEN_HI, LEN_LO and all payload bytes. Sync bytes are excluded.
- States:
  - IDLE: capture=1 → snapshot <= num_in, idx <= 0, chk <= 0, overrun <= 0, go to SEND. busy goes high the next cycle.
  - SEND: when tx_idle=1, register tx_data <= byte[idx], pulse tx_send for exactly 1 cycle, go to WAIT_ACK. While tx_idle=0, hold.
  - WAIT_ACK: wait for tx_idle=0, meaning the UART accepted the byte, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_idle=1.
    - If idx==TOTAL-1: frame_done=1 for 1 cycle, busy=0, go to IDLE.
    - Otherwise: idx++, fold the byte into chk if it is LEN/payload, go to SEND.
- tx_data stays stable from the tx_send cycle until the next tx_send. tx_send is never high on two consecutive cycles.
- Latency: with tx_idle constantly 1, the first tx_send occurs 2 cycles after the capture cycle.
- capture while busy: ignored, snapshot untouched, overrun <= 1. overrun clears only on the next accepted capture or on reset.
- capture in the same cycle frame_done pulses: state is still WAIT_DONE, so the capture counts as busy. It is ignored and sets overrun.
- num_in changing after capture has no effect on the frame in flight.
- Reset mid-frame: tx_send and busy drop immediately (async). No partial frame resumes.

Decomposition:
- Package ecm_pkg:
  - Frame state enum (IDLE, SEND, WAIT_ACK, WAIT_DONE).
  - Default sync byte constants.
  - Function frame_total(num_width, num_cnt, chk_en) returning TOTAL.
  - Function clog2-based index width.
- One natural sub-module, uart_byte_sender: owns the SEND/WAIT_ACK/WAIT_DONE handshake with UARTtx. It takes byte + req and returns done. ecm_result_framer keeps the byte index, the byte mux and the checksum.

Test Plan:
- Defaults, num_in = {256'h0A, 256'h11}, capture, UART model with 10-cycle busy → 69 bytes: 55 AA 02 00, 31×00, 0A, 31×00, 11, then 19. frame_done once; busy high throughout the frame.
- CHECKSUM_EN=0, NUM_WIDTH=16, NUM_CNT=1, num_in=16'hBEEF → exactly 55 AA 00 10 BE EF, then frame_done.
- Capture pulse during byte 5 of a frame → frame content unchanged, overrun=1. The next accepted capture clears overrun and sends the new snapshot.
- tx_idle held 0 for 50 cycles before the first byte → tx_send stays 0 until tx_idle=1, then a single-cycle tx_send with tx_data=8'h55.
- Assert reset during payload byte 20 → tx_send=0 and busy=0 in the same cycle. After release, capture restarts from SYNC0 and a full correct frame follows.
- capture coincident with the frame_done cycle → ignored, overrun=1, no second frame starts.
